pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Program-counter sequencer driving the address input of the Psize x Isize program
//   memory. It holds the PC and selects each cycle between increment, relative branch
//   and absolute jump. It also implements wait-for-switch and halt stalls. Decoded
//   control strobes come from the picoMIPS decoder; the PC output feeds the ROM address.
// PARAMETERS
//   Psize  5  PC/address width; program space is 2**Psize words
// PORTS
//   clk         in   1      system clock, rising edge
//   reset       in   1      synchronous, active-high reset
//   branch_en   in   1      decoder: branch/jump instruction in current cycle
//   branch_rel  in   1      1 = PC-relative (offset), 0 = absolute (target)
//   branch_cond in   1      ALU flag: condition true; branch taken only if 1
//   branch_imm  in   Psize  two's-complement offset (rel) or target address (abs)
//   wait_req    in   1      decoder: wait-for-input instruction
//   halt_req    in   1      decoder: halt instruction
//   go          in   1      external switch, already synchronised to clk
//   PC          out  Psize  current instruction address to program memory
//   fetch_en    out  1      1 when the current instruction executes (state RUN)
//   waiting     out  1      1 in WAIT_HI or WAIT_LO
//   halted      out  1      1 in HALT
// BEHAVIOUR
//   - Reset: a reset sampled high at a clock edge gives PC=0 and state=RUN, so
//     fetch_en=1, waiting=0 and halted=0 from that edge. This applies in any state.
//   - Outputs decode combinationally from the state register. PC is a register.
//     A new PC is visible one clock after the edge that commits it.
//   - In RUN, one update per edge. Priority order:
//     halt_req > wait_req > (branch_en & branch_cond) > increment.
//       halt_req: PC holds; next state HALT.
//       wait_req: PC holds; next state WAIT_HI.
//       taken rel: PC <= PC + branch_imm (Psize-bit add, mod 2**Psize).
//       taken abs: PC <= branch_imm.
//       branch_en with branch_cond=0: PC <= PC+1.
//       default: PC <= PC+1. Wrap: 2**Psize-1 -> 0. No overflow flag.
//   - WAIT_HI: PC holds. go=1 -> WAIT_LO. All decoder strobes are ignored.
//   - WAIT_LO: PC holds. go=0 -> PC <= PC+1 and state RUN. This is a full
//     press-release handshake; a held switch never re-triggers.
//   - HALT: terminal state. PC frozen, all inputs except reset ignored.
//   - A branch with rel offset 0 is a legal self-loop (PC unchanged, stays RUN).
//   - No X propagation: an illegal state encoding recovers to RUN with PC held.
// STRUCTURE
//   - pico_pkg holds:
//       typedef enum logic [1:0] {RUN, WAIT_HI, WAIT_LO, HALT} seq_state_t
//       localparam PSIZE_DEF = 5
//   - One combinational sub-module, pc_next_calc. Inputs: PC, branch fields and the
//     take decision. Output: next-PC candidate (increment/rel/abs mux plus adder).
//   - The top level holds the state FSM and the PC register (always_ff) only.
// TESTING
//   1. reset=1 for 2 cycles, then no strobes for 40 cycles -> PC=0 after reset,
//      counts 0..31, wraps to 0 at cycle 32; fetch_en=1 throughout.
//   2. At PC=10: branch_en=1, rel=1, cond=1, imm=5'b11101 (-3) -> PC=7 next cycle.
//      Then rel=0, imm=20 -> PC=20. Then cond=0 -> PC=21.
//   3. At PC=4: wait_req=1 -> PC stays 4, waiting=1. go=1 at +3 cycles, go=0 at
//      +6 cycles -> PC=5 one cycle after go falls. Branch strobes during the wait
//      are ignored.
//   4. At PC=9: halt_req=1 together with wait_req=1 and a taken branch -> HALT wins.
//      PC=9 and halted=1 for 20 cycles despite go toggling.
//   5. reset=1 while in WAIT_LO, and again while in HALT -> next cycle PC=0,
//      state RUN, waiting=0, halted=0.
//   6. At PC=31: rel branch imm=+2 -> PC=1 (modular wrap). At PC=3: imm=0 -> PC=3
//      repeatedly.

Source files
------------

// File: rtl/pico_pkg.sv
// rtl/pico_pkg.sv - shared types and defaults for the picoMIPS PC sequencer
package pico_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    HALT    = 2'd3
  } seq_state_t;

  localparam int PSIZE_DEF = 5;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - next-PC candidate: increment, relative branch or absolute jump
module pc_next_calc
  import pico_pkg::*;
#(
  parameter int Psize = PSIZE_DEF
) (
  input  logic [Psize-1:0] pc_i,
  input  logic             take_i,
  input  logic             branch_rel_i,
  input  logic [Psize-1:0] branch_imm_i,
  output logic [Psize-1:0] pc_next_o
);

  // Adder operand is the offset for a taken relative branch, otherwise +1;
  // the Psize-bit sum wraps modulo 2**Psize by truncation.
  logic [Psize-1:0] addend;
  logic [Psize-1:0] sum;

  // Select adder operand and final candidate
  always_comb begin
    addend = (take_i && branch_rel_i) ? branch_imm_i : Psize'(1);
    sum    = pc_i + addend;
    if (take_i && !branch_rel_i) begin
      pc_next_o = branch_imm_i;
    end else begin
      pc_next_o = sum;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with wait-for-switch and halt stalls
module pc_sequencer
  import pico_pkg::*;
#(
  parameter int Psize = PSIZE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_en,
  input  logic             branch_rel,
  input  logic             branch_cond,
  input  logic [Psize-1:0] branch_imm,
  input  logic             wait_req,
  input  logic             halt_req,
  input  logic             go,
  output logic [Psize-1:0] PC,
  output logic             fetch_en,
  output logic             waiting,
  output logic             halted
);

  seq_state_t       state_q;
  logic [Psize-1:0] pc_q;
  logic [Psize-1:0] pc_d;
  logic             take_d;

  // A branch is only taken while executing; outside RUN the candidate is PC+1,
  // which is exactly what the WAIT_LO release needs.
  assign take_d = (state_q == RUN) && branch_en && branch_cond;

  pc_next_calc #(
    .Psize(Psize)
  ) u_next (
    .pc_i         (pc_q),
    .take_i       (take_d),
    .branch_rel_i (branch_rel),
    .branch_imm_i (branch_imm),
    .pc_next_o    (pc_d)
  );

  // Sequencer FSM and PC register; stalls hold PC, halt is terminal until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (halt_req) begin
            state_q <= HALT;
          end else if (wait_req) begin
            state_q <= WAIT_HI;
          end else begin
            pc_q <= pc_d;
          end
        end
        WAIT_HI: begin
          if (go) begin
            state_q <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!go) begin
            pc_q    <= pc_d;
            state_q <= RUN;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  // Status outputs decode straight from the state register
  assign PC       = pc_q;
  assign fetch_en = (state_q == RUN);
  assign waiting  = (state_q == WAIT_HI) || (state_q == WAIT_LO);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int PS = 5;

  logic          clk;
  logic          reset;
  logic          branch_en;
  logic          branch_rel;
  logic          branch_cond;
  logic [PS-1:0] branch_imm;
  logic          wait_req;
  logic          halt_req;
  logic          go;
  logic [PS-1:0] PC;
  logic          fetch_en;
  logic          waiting;
  logic          halted;

  int n_cmp;
  int n_err;

  pc_sequencer #(.Psize(PS)) dut (
    .clk         (clk),
    .reset       (reset),
    .branch_en   (branch_en),
    .branch_rel  (branch_rel),
    .branch_cond (branch_cond),
    .branch_imm  (branch_imm),
    .wait_req    (wait_req),
    .halt_req    (halt_req),
    .go          (go),
    .PC          (PC),
    .fetch_en    (fetch_en),
    .waiting     (waiting),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [PS-1:0] pc_e,
                           input logic f_e, input logic w_e, input logic h_e);
    chk({tag, ".pc"}, 32'(PC), 32'(pc_e));
    chk({tag, ".fetch_en"}, 32'(fetch_en), 32'(f_e));
    chk({tag, ".waiting"}, 32'(waiting), 32'(w_e));
    chk({tag, ".halted"}, 32'(halted), 32'(h_e));
  endtask

  task automatic clr_strobes();
    branch_en   = 1'b0;
    branch_rel  = 1'b0;
    branch_cond = 1'b0;
    branch_imm  = '0;
    wait_req    = 1'b0;
    halt_req    = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_strobes();
    go    = 1'b0;
    reset = 1'b1;

    // 1. reset then free-run with wrap
    tick();
    tick();
    reset = 1'b0;
    chk_state("reset", 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("count.pc", 32'(PC), 32'(i % 32));
      chk("count.fetch_en", 32'(fetch_en), 32'd1);
    end
    // PC = 8

    // 2. relative, absolute, not-taken branches
    tick();
    tick();
    chk("pre_br.pc", 32'(PC), 32'd10);
    branch_en = 1'b1; branch_rel = 1'b1; branch_cond = 1'b1; branch_imm = 5'b11101;
    tick();
    chk("br_rel_neg.pc", 32'(PC), 32'd7);
    branch_rel = 1'b0; branch_imm = 5'd20;
    tick();
    chk("br_abs.pc", 32'(PC), 32'd20);
    branch_cond = 1'b0;
    tick();
    chk("br_ntaken.pc", 32'(PC), 32'd21);
    clr_strobes();

    // 3. wait-for-switch handshake, branches ignored while waiting
    for (int i = 0; i < 15; i++) tick();
    chk("pre_wait.pc", 32'(PC), 32'd4);
    wait_req = 1'b1;
    tick();
    chk_state("wait_hi0", 5'd4, 1'b0, 1'b1, 1'b0);
    wait_req = 1'b0;
    branch_en = 1'b1; branch_cond = 1'b1; branch_rel = 1'b0; branch_imm = 5'd17;
    tick();
    chk_state("wait_hi1", 5'd4, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("wait_hi2", 5'd4, 1'b0, 1'b1, 1'b0);
    go = 1'b1;
    tick();
    chk_state("wait_lo0", 5'd4, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("wait_lo1", 5'd4, 1'b0, 1'b1, 1'b0);
    tick();
    chk_state("wait_lo2", 5'd4, 1'b0, 1'b1, 1'b0);
    go = 1'b0;
    clr_strobes();
    tick();
    chk_state("wait_rel", 5'd5, 1'b1, 1'b0, 1'b0);

    // 4. halt has priority and is terminal
    for (int i = 0; i < 4; i++) tick();
    chk("pre_halt.pc", 32'(PC), 32'd9);
    halt_req = 1'b1; wait_req = 1'b1;
    branch_en = 1'b1; branch_cond = 1'b1; branch_rel = 1'b0; branch_imm = 5'd25;
    for (int i = 0; i < 20; i++) begin
      tick();
      go = ~go;
      chk_state("halt", 5'd9, 1'b0, 1'b0, 1'b1);
    end
    clr_strobes();
    go = 1'b0;

    // 5. reset out of HALT and out of WAIT_LO
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_state("rst_halt", 5'd0, 1'b1, 1'b0, 1'b0);
    wait_req = 1'b1;
    tick();
    wait_req = 1'b0;
    go = 1'b1;
    tick();
    chk_state("pre_rst_wlo", 5'd0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    go = 1'b0;
    chk_state("rst_wlo", 5'd0, 1'b1, 1'b0, 1'b0);

    // 6. modular relative wrap and zero-offset self-loop
    for (int i = 0; i < 31; i++) tick();
    chk("pre_wrap.pc", 32'(PC), 32'd31);
    branch_en = 1'b1; branch_rel = 1'b1; branch_cond = 1'b1; branch_imm = 5'd2;
    tick();
    chk("br_wrap.pc", 32'(PC), 32'd1);
    clr_strobes();
    tick();
    tick();
    chk("pre_loop.pc", 32'(PC), 32'd3);
    branch_en = 1'b1; branch_rel = 1'b1; branch_cond = 1'b1; branch_imm = 5'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_state("self_loop", 5'd3, 1'b1, 1'b0, 1'b0);
    end
    clr_strobes();
    tick();
    chk("post_loop.pc", 32'(PC), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
